// File: rtl/ad2512_pkg.sv
// Shared definitions for the AD2512 register read-back path: FSM encoding,
// SPI frame geometry and LUT entry field layout.
package ad2512_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_CHECK,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int FRAME_BITS = 24;
    localparam int INSTR_BITS = 16;

    localparam logic        RD_BIT        = 1'b1;
    localparam logic [15:0] SENTINEL_ADDR = 16'hFFFF;

    // LUT entry layout: {reg_addr[15:0], expected[7:0]}
    localparam int LUT_ADDR_MSB = 23;
    localparam int LUT_ADDR_LSB = 8;
    localparam int LUT_EXP_MSB  = 7;
    localparam int LUT_EXP_LSB  = 0;

    // Read instruction: R/W bit, two-bit length field (single byte), 13-bit address,
    // followed by eight don't-care clocks during which the ADC returns data.
    function automatic logic [FRAME_BITS-1:0] build_read_word(input logic [15:0] reg_addr);
        return {RD_BIT, 2'b00, reg_addr[12:0], 8'h00};
    endfunction

endpackage

// File: rtl/ad2512_spi_shifter.sv
// Mode-0 SPI bit engine: 24-bit shift register, SCLK divider and bit counter.
// Chip select is owned by the caller so the same engine serves reads and writes.
module ad2512_spi_shifter
    import ad2512_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [FRAME_BITS-1:0] load_word,
    input  logic                  go,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  done,
    output logic [FRAME_BITS-1:0] rx_word
);

    // Handshake: 'load' (while idle) captures load_word and presents bit 23 on mosi;
    // 'go' starts 24 SCLK periods; 'done' is high for one cycle on the clk cycle
    // that issues the 24th falling edge, after which the engine is idle again.

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'(FRAME_BITS - 1);

    logic                  active;
    logic                  sclk_q;
    logic [7:0]            div_cnt;
    logic [4:0]            bit_cnt;
    logic [FRAME_BITS-1:0] tx_q;
    logic [FRAME_BITS-1:0] rx_q;
    logic                  half_end;

    assign half_end = active && (div_cnt == DIV_LAST);
    assign done     = half_end && sclk_q && (bit_cnt == BIT_LAST);
    assign sclk     = sclk_q;
    assign mosi     = tx_q[FRAME_BITS-1];
    assign rx_word  = rx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            sclk_q  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            if (load && !active) begin
                tx_q <= load_word;
                rx_q <= '0;
            end
            if (go && !active) begin
                active  <= 1'b1;
                sclk_q  <= 1'b0;
                div_cnt <= '0;
                bit_cnt <= '0;
            end else if (active) begin
                if (half_end) begin
                    div_cnt <= '0;
                    if (!sclk_q) begin
                        // rising edge issued; MISO captured in the same cycle
                        sclk_q <= 1'b1;
                        rx_q   <= {rx_q[FRAME_BITS-2:0], miso};
                    end else begin
                        sclk_q  <= 1'b0;
                        tx_q    <= {tx_q[FRAME_BITS-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == BIT_LAST) begin
                            active <= 1'b0;
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ad2512_reg_readback.sv
// Walks the ADC configuration LUT, reads each register back over SPI and reports
// per-register data. Define AD2512_READ_COMPARE_EN to build the expected-value comparator.
module ad2512_reg_readback
    import ad2512_pkg::*;
#(
    parameter int CLK_DIV     = 4,
    parameter int START_INDEX = 1,
    parameter int LUT_NUM     = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [9:0]  lut_index,
    input  logic [23:0] lut_data,
    output logic        spi_csn,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    output logic        busy,
    output logic        done,
    output logic        rd_valid,
    output logic [15:0] rd_addr,
    output logic [7:0]  rd_data,
    output logic        error,
    output logic [7:0]  err_count
);

    localparam logic [7:0] TMR_LAST  = 8'(CLK_DIV - 1);
    localparam logic [9:0] IDX_FIRST = 10'(START_INDEX);
    localparam logic [9:0] IDX_END   = 10'(LUT_NUM);

    state_t                state;
    state_t                next_state;
    logic [7:0]            tmr;
    logic                  tmr_last;
    logic [15:0]           lut_addr;
    logic [7:0]            lut_exp;
    logic [15:0]           addr_q;
    logic [7:0]            exp_q;
    logic                  sh_load;
    logic                  sh_go;
    logic                  sh_done;
    logic [FRAME_BITS-1:0] sh_rx;
    logic                  accept;

    assign lut_addr = lut_data[LUT_ADDR_MSB:LUT_ADDR_LSB];
    assign lut_exp  = lut_data[LUT_EXP_MSB:LUT_EXP_LSB];
    assign tmr_last = (tmr == TMR_LAST);
    assign accept   = (state == ST_IDLE) && start;

    ad2512_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (sh_load),
        .load_word (build_read_word(lut_addr)),
        .go        (sh_go),
        .miso      (spi_miso),
        .sclk      (spi_sclk),
        .mosi      (spi_mosi),
        .done      (sh_done),
        .rx_word   (sh_rx)
    );

    always_comb begin
        next_state = state;
        sh_load    = 1'b0;
        sh_go      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                if (lut_addr == SENTINEL_ADDR || lut_index >= IDX_END) begin
                    next_state = ST_DONE;
                end else begin
                    sh_load    = 1'b1;
                    next_state = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (tmr_last) begin
                    sh_go      = 1'b1;
                    next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sh_done) next_state = ST_CS_HOLD;
            end
            ST_CS_HOLD: begin
                if (tmr_last) next_state = ST_CHECK;
            end
            ST_CHECK: next_state = ST_GAP;
            ST_GAP: begin
                if (tmr_last) next_state = ST_LOAD;
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tmr       <= '0;
            spi_csn   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_addr   <= '0;
            rd_data   <= '0;
            lut_index <= IDX_FIRST;
            addr_q    <= '0;
            exp_q     <= '0;
        end else begin
            state    <= next_state;
            tmr      <= (next_state != state) ? 8'd0 : tmr + 8'd1;
            spi_csn  <= !(next_state inside {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD});
            busy     <= !(next_state inside {ST_IDLE, ST_DONE});
            done     <= (next_state == ST_DONE);
            rd_valid <= (next_state == ST_CHECK);
            if (accept) begin
                lut_index <= IDX_FIRST;
            end else if (state == ST_GAP && tmr_last) begin
                lut_index <= lut_index + 10'd1;
            end
            if (state == ST_LOAD) begin
                addr_q <= lut_addr;
                exp_q  <= lut_exp;
            end
            if (next_state == ST_CHECK) begin
                rd_addr <= addr_q;
                rd_data <= sh_rx[7:0];
            end
        end
    end

    logic unused_bits;

`ifdef AD2512_READ_COMPARE_EN
    logic       error_q;
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_q   <= 1'b0;
            err_cnt_q <= '0;
        end else if (accept) begin
            error_q   <= 1'b0;
            err_cnt_q <= '0;
        end else if (next_state == ST_CHECK && sh_rx[7:0] != exp_q) begin
            error_q <= 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign error       = error_q;
    assign err_count   = err_cnt_q;
    assign unused_bits = ^sh_rx[FRAME_BITS-1:8];
`else
    assign error       = 1'b0;
    assign err_count   = 8'h00;
    assign unused_bits = ^{exp_q, sh_rx[FRAME_BITS-1:8]};
`endif

endmodule

// File: tb/tb_ad2512_reg_readback.sv
// Bench for ad2512_reg_readback: LUT and SPI slave models, table of read-back
// passes, plus hand sequences for reset state and reset mid-frame.
module tb_ad2512_reg_readback;

    localparam int CLK_DIV  = 4;
    localparam int FRAME_LEN = 24 * 2 * CLK_DIV + 2 * CLK_DIV;

`ifdef AD2512_READ_COMPARE_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  lut_index;
    logic [23:0] lut_data;
    logic        spi_csn, spi_sclk, spi_mosi, spi_miso;
    logic        busy, done, rd_valid, error;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data, err_count;

    always #5 clk = ~clk;

    ad2512_reg_readback #(
        .CLK_DIV     (CLK_DIV),
        .START_INDEX (1),
        .LUT_NUM     (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .lut_index (lut_index),
        .lut_data  (lut_data),
        .spi_csn   (spi_csn),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .busy      (busy),
        .done      (done),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .error     (error),
        .err_count (err_count)
    );

    // ---------------- LUT model ----------------
    logic [7:0] base_mem [8];
    int         lut_mode = 0;   // 0: index 5 is the 16'hFFFF sentinel; 1: valid through index 7

    function automatic logic [23:0] lut_model(input logic [9:0] idx, input int mode);
        logic [2:0] k;
        k = idx[2:0];
        if (idx == 10'd0) return 24'h000000;
        if (mode == 0 && idx == 10'd5) return {16'hFFFF, 8'h00};
        if (idx <= 10'd7) return {6'b0, idx, base_mem[k]};
        return {6'b0, idx, 8'h00};
    endfunction

    assign lut_data = lut_model(lut_index, lut_mode);

    // ---------------- monitor + SPI slave ----------------
    logic [7:0]  slave_mem [16];
    logic [7:0]  slave_byte;
    logic [23:0] frame_word;
    logic [23:0] frames[$];
    int          lens[$];
    logic [23:0] rd_log[$];
    int          frame_len, rises, done_cnt, align_err;
    logic        prev_csn, prev_sclk, prev_mosi;

    initial begin
        spi_miso = 1'b0;
        prev_csn = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0;
        frame_len = 0; rises = 0; done_cnt = 0; align_err = 0;
        frame_word = '0; slave_byte = '0;
        forever begin
            @(negedge clk);
            if (prev_csn && !spi_csn) begin
                frame_len = 0; rises = 0; frame_word = '0; spi_miso = 1'b0;
                if (spi_sclk) align_err++;
            end
            if (!spi_csn) frame_len++;
            if (!prev_csn && spi_csn) begin
                frames.push_back(frame_word);
                lens.push_back(frame_len);
                if (prev_sclk || spi_sclk) align_err++;
            end
            // mode 0: MOSI may only change while SCLK is low
            if (spi_sclk && spi_mosi != prev_mosi) align_err++;
            if (!spi_csn && !prev_sclk && spi_sclk) begin
                frame_word = {frame_word[22:0], spi_mosi};
                rises++;
                if (rises == 16) slave_byte = slave_mem[frame_word[3:0]];
            end
            if (!spi_csn && prev_sclk && !spi_sclk) begin
                if (rises >= 16 && rises <= 23) spi_miso = slave_byte[23 - rises];
                else spi_miso = 1'b0;
            end
            if (done) done_cnt++;
            if (rd_valid) rd_log.push_back({rd_addr, rd_data});
            prev_csn = spi_csn; prev_sclk = spi_sclk; prev_mosi = spi_mosi;
        end
    end

    // ---------------- scoreboard ----------------
    int          n_checks = 0;
    int          n_pass = 0;
    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    typedef struct {
        int          lut_mode;
        logic [15:0] bad_addr;
        logic [7:0]  bad_val;
        int          n_reads;
        bit          restart;
        bit          exp_error;
        logic [7:0]  exp_errcnt;
    } vec_t;

    vec_t vecs[5];

    // ---------------- driver tasks ----------------
    task automatic set_slave(input logic [15:0] bad_addr, input logic [7:0] bad_val);
        for (int k = 0; k < 16; k++) slave_mem[k] = (k < 8) ? base_mem[k] : 8'h00;
        if (bad_addr != 16'h0) slave_mem[bad_addr[3:0]] = bad_val;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_pass(input int id, input vec_t v);
        bit          seen;
        logic [7:0]  dv;
        logic [23:0] got;
        lut_mode = v.lut_mode;
        set_slave(v.bad_addr, v.bad_val);
        frames.delete(); lens.delete(); rd_log.delete(); exp_q.delete();
        done_cnt = 0; align_err = 0;
        for (int a = 1; a <= v.n_reads; a++) begin
            dv = (16'(a) == v.bad_addr) ? v.bad_val : base_mem[a];
            exp_q.push_back({16'(a), dv});
        end
        pulse_start();
        if (v.restart) begin
            repeat (300) @(negedge clk);
            start = 1'b1; @(negedge clk); start = 1'b0;
            repeat (500) @(negedge clk);
            start = 1'b1; @(negedge clk); start = 1'b0;
        end
        wait_done(4000, seen);
        check($sformatf("v%0d_done_seen", id), 32'(seen), 32'd1);
        check($sformatf("v%0d_busy_at_done", id), 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        check($sformatf("v%0d_done_pulses", id), done_cnt, 1);
        check($sformatf("v%0d_rd_valid_pulses", id), rd_log.size(), v.n_reads);
        check($sformatf("v%0d_csn_frames", id), frames.size(), v.n_reads);
        while (exp_q.size() > 0 && rd_log.size() > 0) begin
            got = rd_log.pop_front();
            check($sformatf("v%0d_read_%0h", id, got[23:8]), got, exp_q.pop_front());
        end
        for (int j = 0; j < frames.size(); j++) begin
            check($sformatf("v%0d_mosi_frame%0d", id, j), frames[j], {1'b1, 2'b00, 13'(j + 1), 8'h00});
            check($sformatf("v%0d_csn_len%0d", id, j), lens[j], FRAME_LEN);
        end
        check($sformatf("v%0d_mode0_align", id), align_err, 0);
        check($sformatf("v%0d_error", id), 32'(error), 32'(v.exp_error & CMP_EN));
        check($sformatf("v%0d_err_count", id), err_count, CMP_EN ? v.exp_errcnt : 8'h00);
        check($sformatf("v%0d_busy_after", id), 32'(busy), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit seen;
        base_mem[0] = 8'h00; base_mem[1] = 8'h00; base_mem[2] = 8'h01; base_mem[3] = 8'h04;
        base_mem[4] = 8'h00; base_mem[5] = 8'h11; base_mem[6] = 8'h22; base_mem[7] = 8'h33;
        set_slave(16'h0, 8'h00);
        vecs[0] = '{0, 16'h0000, 8'h00, 4, 1'b0, 1'b0, 8'd0};  // default pass, sentinel at index 5
        vecs[1] = '{0, 16'h0002, 8'h05, 4, 1'b0, 1'b1, 8'd1};  // ADC returns 0x05 at 0x0002
        vecs[2] = '{1, 16'h0000, 8'h00, 7, 1'b0, 1'b0, 8'd0};  // stops on LUT_NUM, error cleared
        vecs[3] = '{1, 16'h0006, 8'h99, 7, 1'b0, 1'b1, 8'd1};
        vecs[4] = '{0, 16'h0000, 8'h00, 4, 1'b1, 1'b0, 8'd0};  // start pulsed while busy

        rst_n = 1'b0; start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_csn", 32'(spi_csn), 32'd1);
        check("reset_sclk", 32'(spi_sclk), 32'd0);
        check("reset_mosi", 32'(spi_mosi), 32'd0);
        check("reset_lut_index", lut_index, 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_rd_addr", rd_addr, 32'd0);
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_err_count", err_count, 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_pass(i, vecs[i]);
            if (i == 0) check("frame_addr_0x0003", frames[2], 24'h800300);
        end

        // reset asserted asynchronously during SCLK period 10
        lut_mode = 0;
        set_slave(16'h0, 8'h00);
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (!spi_csn && rises == 10) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_reached_period10", 32'(seen), 32'd1);
        check("abort_sclk_high_before", 32'(spi_sclk), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_csn_immediate", 32'(spi_csn), 32'd1);
        check("abort_sclk_immediate", 32'(spi_sclk), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_busy_after_release", 32'(busy), 32'd0);
        check("abort_lut_index", lut_index, 32'd1);
        run_pass(5, vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ad2512_reg_readback.md
Name: ad2512_reg_readback

Overview:
- Read-back counterpart of the ADC register configuration path.
- After configuration, it walks the same register LUT (16-bit address, 8-bit expected value).
- For each entry it issues an SPI read frame to the ADC, captures the returned byte, compares it against the expected value and reports per-register data plus a pass/fail summary.
- Sits between the config LUT and the ADC SPI pins. The SPI pins are muxed with the config writer by the top level; only one of the two is active at a time.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range 2..255.
- START_INDEX, 1, first LUT index read; index 0 is the self-clearing reset register and is skipped.
- LUT_NUM, 5, one past the last LUT index read.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a read-back pass when idle
- lut_index  out  10  LUT address presented to the config LUT
- lut_data  in  24  {reg_addr[15:0], expected[7:0]} from the LUT, combinational
- spi_csn  out  1  chip select, active low
- spi_sclk  out  1  SPI clock, idle low (mode 0)
- spi_mosi  out  1  serial instruction out, MSB first
- spi_miso  in  1  serial read data in
- busy  out  1  high from start accept until done
- done  out  1  single-cycle pulse at end of pass
- rd_valid  out  1  single-cycle pulse per completed register read
- rd_addr  out  16  address of the register just read
- rd_data  out  8  byte returned by the ADC
- error  out  1  sticky mismatch flag for the current pass
- err_count  out  8  mismatches this pass, saturating at 255

Behaviour:
- Reset values: spi_csn=1, spi_sclk=0, spi_mosi=0, lut_index=START_INDEX, busy=0, done=0, rd_valid=0, rd_addr=0, rd_data=0, error=0, err_count=0.
- Asynchronous reset mid-frame: spi_csn rises and spi_sclk falls immediately; FSM returns to IDLE.
- FSM states: IDLE, LOAD, CS_SETUP, SHIFT, CS_HOLD, CHECK, GAP, DONE.
- IDLE:
  - start=1 → LOAD; clear error and err_count; busy=1; lut_index=START_INDEX.
  - start while busy is ignored.
- LOAD (1 cycle):
  - Latch lut_data.
  - If reg_addr==16'hFFFF (LUT default entry) or lut_index==LUT_NUM → DONE.
  - Otherwise build shift word {1'b1, 2'b00, reg_addr[12:0], 8'h00} → CS_SETUP.
- CS_SETUP:
  - spi_csn=0; spi_mosi=bit 23 of the shift word.
  - Wait CLK_DIV cycles → SHIFT.
- SHIFT: 24 SCLK periods, each made of CLK_DIV cycles low then CLK_DIV cycles high.
  - spi_sclk rises at the end of the low half; spi_miso is sampled in the same clk cycle the rise is issued.
  - The next MOSI bit is driven on the clk cycle spi_sclk falls.
  - MISO samples for bits 7..0 (SCLK periods 17..24) shift into rd_data MSB first.
  - MOSI is 0 during the data phase.
  - After the 24th falling edge → CS_HOLD.
- CS_HOLD:
  - CLK_DIV cycles with csn low and sclk low, then spi_csn=1 → CHECK.
- CHECK (1 cycle):
  - rd_valid=1; rd_addr=latched address.
  - On mismatch with expected: error=1 and err_count increments, saturating at 255.
- GAP:
  - CLK_DIV cycles with csn high (minimum deassert time).
  - lut_index increments → LOAD.
- DONE (1 cycle):
  - done=1; busy=0 → IDLE.
  - error and err_count hold until the next start.
- Frame length: 24×2×CLK_DIV + 2×CLK_DIV cycles with csn low, i.e. 200 cycles at CLK_DIV=4.

Optional Feature:
- Macro: AD2512_READ_COMPARE_EN.
- Defined: CHECK compares rd_data with the expected byte; error and err_count are live.
- Undefined: no comparator is built; error and err_count are tied to 0; rd_valid, rd_addr and rd_data are unchanged.

Decomposition:
- Shared package ad2512_pkg holds:
  - FSM state encoding.
  - FRAME_BITS=24, INSTR_BITS=16.
  - RD_BIT=1'b1.
  - SENTINEL_ADDR=16'hFFFF.
  - Field offsets of the LUT entry.
- One sub-module, ad2512_spi_shifter, owns the 24-bit shift register, SCLK divider and bit counter. It uses a load/go/done handshake and is reusable by the config writer.

Test Plan:
- Default run: slave model holds {0x01:0x00, 0x02:0x01, 0x03:0x04, 0x04:0x00}; start → 4 rd_valid pulses with addr 1..4 and matching data; done; error=0; err_count=0.
- MOSI frame check for address 0x0003: bits shifted = 24'h800300; spi_csn low for exactly 200 clk at CLK_DIV=4; mode-0 edge alignment checked.
- Mismatch: model returns 0x05 at 0x0002 → rd_data=0x05 on the second pulse; error=1; err_count=1 (with the macro); both stay 0 without the macro.
- Sentinel: LUT_NUM=8 so index 5 returns 16'hFFFF → done after 4 reads, with no fifth csn assertion.
- Async reset asserted at SCLK period 10 → spi_csn=1 and spi_sclk=0 in the same cycle; after release, busy=0; a new start gives a clean full pass.
- start pulsed while busy → ignored; exactly one done and 4 rd_valid pulses.
